// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared CPU defines for exception codes, stall encodings and controller states
package pipe_ctrl_pkg;
   localparam logic [4:0] EXC_NONE = 5'h10;
   localparam logic [4:0] EXC_ERET = 5'h11;
   localparam logic [3:0] STALL_NONE = 4'b0000;
   localparam logic [3:0] STALL_ID = 4'b0111;
   localparam logic [3:0] STALL_EXE = 4'b1111;
   typedef enum logic {RUN, FLUSHED} state_t;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush control; optional stall watchdog enabled by PIPE_CTRL_WDOG_EN
import pipe_ctrl_pkg::*;
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_exe,
   input  logic [4:0]  mem_exccode,
   input  logic [31:0] cp0_epc,
   output logic [3:0]  stall,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic [31:0] stall_cnt,
   output logic        wdog_err
);
   state_t state, state_nx;
   logic exc_valid;
   logic [3:0] stall_req;
   always_comb begin
      exc_valid = (state == RUN) && (mem_exccode != EXC_NONE);
      flush = exc_valid;
      flush_pc = !exc_valid ? 32'h0 : (mem_exccode == EXC_ERET) ? cp0_epc : EXC_VECTOR;
      stall_req = (state != RUN || exc_valid) ? STALL_NONE :
                  stallreq_exe ? STALL_EXE : stallreq_id ? STALL_ID : STALL_NONE;
      state_nx = exc_valid ? FLUSHED : RUN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         stall_cnt <= 32'h0;
      end else begin
         state <= state_nx;
         if (stall != STALL_NONE) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`ifdef PIPE_CTRL_WDOG_EN
   logic [7:0] wdog_cnt;
   assign stall = (wdog_cnt == WDOG_LIMIT) ? STALL_NONE : stall_req;
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= 8'd0;
         wdog_err <= 1'b0;
      end else begin
         wdog_cnt <= (stall == STALL_NONE || flush) ? 8'd0 : wdog_cnt + 8'd1;
         if (stall != STALL_NONE && wdog_cnt + 8'd1 == WDOG_LIMIT) wdog_err <= 1'b1;
      end
   end
`else
   assign stall = stall_req;
   assign wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table plus scoreboard checks for pipe_ctrl
module tb_pipe_ctrl;
   logic clk = 1'b0, rst = 1'b1, stallreq_id = 1'b0, stallreq_exe = 1'b0;
   logic [4:0] mem_exccode = 5'h10;
   logic [31:0] cp0_epc = 32'h0;
   logic [3:0] stall;
   logic flush, wdog_err;
   logic [31:0] flush_pc, stall_cnt;
`ifdef PIPE_CTRL_WDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif
   pipe_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .WDOG_LIMIT(8'd4)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_exe(stallreq_exe),
      .mem_exccode(mem_exccode), .cp0_epc(cp0_epc), .stall(stall), .flush(flush),
      .flush_pc(flush_pc), .stall_cnt(stall_cnt), .wdog_err(wdog_err));
   always #5 clk = ~clk;
   typedef struct {
      logic id; logic exe; logic [4:0] exc; logic [31:0] epc;
      logic [3:0] stall; logic flush; logic [31:0] pc;
   } vec_t;
   typedef struct {
      logic [3:0] stall; logic flush; logic [31:0] pc; logic [31:0] cnt; logic wdog;
   } exp_t;
   exp_t sbq[$];
   vec_t tbl[18];
   int checks = 0, passed = 0;
   logic [31:0] exp_cnt = 32'h0;
   logic exp_wdog = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask
   task automatic cyc(input string name, input logic id, input logic exe, input logic [4:0] exc,
                      input logic [31:0] epc, input logic [3:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc);
      exp_t e;
      stallreq_id = id;
      stallreq_exe = exe;
      mem_exccode = exc;
      cp0_epc = epc;
      sbq.push_back('{e_stall, e_flush, e_pc, exp_cnt, exp_wdog});
      @(negedge clk);
      e = sbq.pop_front();
      chk({name, " stall"}, {28'h0, stall}, {28'h0, e.stall});
      chk({name, " flush"}, {31'h0, flush}, {31'h0, e.flush});
      chk({name, " flush_pc"}, flush_pc, e.pc);
      chk({name, " stall_cnt"}, stall_cnt, e.cnt);
      chk({name, " wdog_err"}, {31'h0, wdog_err}, {31'h0, e.wdog});
      if (rst) begin
         exp_cnt = 32'h0;
         exp_wdog = 1'b0;
      end else if (e_stall != 4'b0000) exp_cnt = exp_cnt + 32'd1;
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input string name);
      cyc(name, 1'b0, 1'b0, 5'h10, 32'h0, 4'b0000, 1'b0, 32'h0);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0]  = '{1'b1, 1'b0, 5'h10, 32'h0, 4'b0111, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b0, 5'h10, 32'h0, 4'b0111, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b0, 5'h10, 32'h0, 4'b0111, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 5'h10, 32'h0, 4'b0000, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 1'b0, 5'h10, 32'h0, 4'b0111, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 1'b0, 5'h10, 32'h0, 4'b0000, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 5'h08, 32'h0, 4'b0000, 1'b1, 32'hBFC0_0380};
      tbl[8]  = '{1'b0, 1'b1, 5'h08, 32'h0, 4'b0000, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 1'b0, 5'h10, 32'h0, 4'b0000, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 1'b0, 5'h11, 32'h8000_1234, 4'b0000, 1'b1, 32'h8000_1234};
      tbl[12] = '{1'b0, 1'b0, 5'h11, 32'h8000_1234, 4'b0000, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 1'b0, 5'h10, 32'h8000_1234, 4'b0000, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 1'b0, 5'h11, 32'h0000_0ABC, 4'b0000, 1'b1, 32'h0000_0ABC};
      tbl[15] = '{1'b1, 1'b0, 5'h10, 32'h0, 4'b0000, 1'b0, 32'h0};
      tbl[16] = '{1'b0, 1'b0, 5'h1F, 32'h1234_5678, 4'b0000, 1'b1, 32'hBFC0_0380};
      tbl[17] = '{1'b0, 1'b0, 5'h10, 32'h0, 4'b0000, 1'b0, 32'h0};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle("reset");
      for (int i = 0; i < 18; i++)
         cyc($sformatf("row%0d", i), tbl[i].id, tbl[i].exe, tbl[i].exc, tbl[i].epc,
             tbl[i].stall, tbl[i].flush, tbl[i].pc);
      // reset while FLUSHED must clear the counter
      cyc("exc_pre_rst", 1'b0, 1'b0, 5'h08, 32'h0, 4'b0000, 1'b1, 32'hBFC0_0380);
      rst = 1'b1;
      cyc("flushed_rst", 1'b0, 1'b1, 5'h08, 32'h0, 4'b0000, 1'b0, 32'h0);
      rst = 1'b0;
      cyc("after_rst", 1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
      idle("after_rst_idle");
      // reset on the exception edge must land in RUN, not FLUSHED
      rst = 1'b1;
      cyc("exc_with_rst", 1'b0, 1'b0, 5'h08, 32'h0, 4'b0000, 1'b1, 32'hBFC0_0380);
      rst = 1'b0;
      cyc("run_after_exc_rst", 1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
      idle("pre_wrap");
      force dut.stall_cnt = 32'hFFFF_FFFE;
      release dut.stall_cnt;
      exp_cnt = 32'hFFFF_FFFE;
      cyc("wrap0", 1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
      cyc("wrap1", 1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
      idle("wrapped");
      for (int i = 0; i < 4; i++)
         cyc($sformatf("wdog_hold%0d", i), 1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
      exp_wdog = WDOG;
      cyc("wdog_trip", 1'b0, 1'b1, 5'h10, 32'h0, WDOG ? 4'b0000 : 4'b1111, 1'b0, 32'h0);
      cyc("wdog_resume", 1'b0, 1'b1, 5'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
      idle("wdog_sticky");
      rst = 1'b1;
      idle("wdog_rst");
      rst = 1'b0;
      idle("wdog_cleared");
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
